// File: rtl/lfu_pkg.sv
// Shared constants and types for the LFU buffer scheduler.
package lfu_pkg;
  localparam int NUM_BUF   = 4;
  localparam int BUF_W     = 2;
  localparam int NUM_REQ   = 2;
  localparam int CNT_W_DEF = 3;

  localparam logic REQ_REF = 1'b0;
  localparam logic REQ_NEW = 1'b1;

  typedef logic [BUF_W-1:0] buf_idx_t;
endpackage

// File: rtl/lfu_min_sel.sv
// Combinational minimum finder over the buffer use counters; ties resolve to the lowest index.
module lfu_min_sel
  import lfu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [NUM_BUF-1:0][CNT_W-1:0] cnt,
  output buf_idx_t                      idx
);
  logic [CNT_W-1:0] best;

  // Strict less-than keeps the earliest index on equal counts.
  always_comb begin
    idx  = '0;
    best = cnt[0];
    for (int i = 1; i < NUM_BUF; i++) begin
      if (cnt[i] < best) begin
        idx  = buf_idx_t'(i);
        best = cnt[i];
      end
    end
  end
endmodule

// File: rtl/lfu_buf_sched.sv
// Two-requester round-robin front end for a four-buffer pool with LFU replacement and counter aging.
module lfu_buf_sched
  import lfu_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int CNT_INIT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ-1:0]       req_new,
  input  logic [NUM_REQ*BUF_W-1:0] req_buf,
  output logic [NUM_REQ-1:0]       ack,
  output logic [BUF_W-1:0]         ack_buf,
  output logic                     ack_new,
  output logic [NUM_BUF*CNT_W-1:0] cnt_flat
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);

  logic [NUM_BUF-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NUM_REQ-1:0][BUF_W-1:0] bufs;
  logic [NUM_REQ-1:0]            elig;
  logic                          rr, any, win, sel_new;
  buf_idx_t                      sel_buf, victim, tgt;

  assign bufs     = req_buf;
  assign cnt_flat = cnt;

  // A request already acked this cycle is masked so a held request is not taken twice.
  assign elig    = req_vld & ~ack;
  assign any     = |elig;
  assign win     = (&elig) ? rr : elig[1];
  assign sel_new = (req_new[win] == REQ_NEW);
  assign sel_buf = bufs[win];
  assign tgt     = sel_new ? victim : sel_buf;

  lfu_min_sel #(.CNT_W(CNT_W)) u_min_sel (
    .cnt (cnt),
    .idx (victim)
  );

  // Hitting a saturated counter halves the whole bank before the increment.
  always_comb begin
    cnt_nxt = cnt;
    if (any) begin
      if (sel_new) begin
        cnt_nxt[victim] = CNT_RST;
      end else if (cnt[sel_buf] == CNT_MAX) begin
        for (int i = 0; i < NUM_BUF; i++) cnt_nxt[i] = cnt[i] >> 1;
        cnt_nxt[sel_buf] = (CNT_MAX >> 1) + CNT_W'(1);
      end else begin
        cnt_nxt[sel_buf] = cnt[sel_buf] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= {NUM_BUF{CNT_RST}};
      ack     <= '0;
      ack_buf <= '0;
      ack_new <= 1'b0;
      rr      <= 1'b0;
    end else begin
      ack <= '0;
      if (any) begin
        cnt      <= cnt_nxt;
        ack[win] <= 1'b1;
        ack_buf  <= tgt;
        ack_new  <= sel_new;
        rr       <= ~win;
      end
    end
  end
endmodule

// File: tb/tb_lfu_buf_sched.sv
// Self-checking bench: directed vector table, hand sequences, and a random run against a queue-free LFU model.
module tb_lfu_buf_sched;
  localparam int CW    = 3;
  localparam int MAXV  = (1 << CW) - 1;
  localparam int CINIT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_vld = '0, req_new = '0;
  logic [3:0]  req_buf = '0;
  logic [1:0]  ack;
  logic [1:0]  ack_buf;
  logic        ack_new;
  logic [11:0] cnt_flat;

  int checks = 0;
  int errors = 0;

  lfu_buf_sched #(.CNT_W(CW), .CNT_INIT(CINIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_new  (req_new),
    .req_buf  (req_buf),
    .ack      (ack),
    .ack_buf  (ack_buf),
    .ack_new  (ack_new),
    .cnt_flat (cnt_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  nw;
    logic [3:0]  bf;
    logic [1:0]  e_ack;
    logic [1:0]  e_buf;
    logic        e_new;
    logic [11:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  // reference model state
  int        m[4];
  bit  [1:0] mack;
  int        mbuf;
  bit        mnew;
  bit        mrr;

  function automatic logic [11:0] c4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] n, input logic [3:0] b,
                              input logic [1:0] ea, input logic [1:0] eb, input logic en,
                              input logic [11:0] ec);
    vec_t t;
    t.vld = v; t.nw = n; t.bf = b; t.e_ack = ea; t.e_buf = eb; t.e_new = en; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = '0; req_new = '0; req_buf = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m[i] = CINIT;
    mack = '0; mbuf = 0; mnew = 1'b0; mrr = 1'b0;
  endtask

  // one isolated request: assert, wait for the ack, then drop for a cycle
  task automatic issue(input int r, input logic nw, input logic [1:0] b,
                       input int e_buf, input string nm);
    req_vld = '0; req_new = '0; req_buf = '0;
    req_vld[r] = 1'b1;
    req_new[r] = nw;
    if (r == 0) req_buf[1:0] = b; else req_buf[3:2] = b;
    step();
    chk({nm, "_ack"}, ack, 1 << r);
    chk({nm, "_buf"}, ack_buf, e_buf);
    chk({nm, "_new"}, ack_new, nw);
    req_vld = '0;
    step();
  endtask

  task automatic model_step(input logic [1:0] v, input logic [1:0] n, input logic [3:0] b);
    bit [1:0] el;
    int w, tg;
    el = v & ~mack;
    mack = '0;
    if (el != 2'b00) begin
      if (el == 2'b11) w = mrr; else w = el[1] ? 1 : 0;
      mrr = (w == 0);
      tg = (w == 1) ? int'(b[3:2]) : int'(b[1:0]);
      if (n[w]) begin
        tg = 0;
        for (int i = 1; i < 4; i++) if (m[i] < m[tg]) tg = i;
        m[tg] = CINIT;
        mnew = 1'b1;
      end else begin
        if (m[tg] == MAXV) for (int i = 0; i < 4; i++) m[i] = m[i] / 2;
        m[tg] = m[tg] + 1;
        mnew = 1'b0;
      end
      mack[w] = 1'b1;
      mbuf = tg;
    end
  endtask

  initial begin
    tbl[0] = mk(2'b01, 2'b01, 4'b0000, 2'b01, 2'd0, 1'b1, c4(1,1,1,1));
    tbl[1] = mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 1'b1, c4(1,1,1,1));
    tbl[2] = mk(2'b10, 2'b00, 4'b1000, 2'b10, 2'd2, 1'b0, c4(1,1,2,1));
    tbl[3] = mk(2'b00, 2'b00, 4'b1000, 2'b00, 2'd2, 1'b0, c4(1,1,2,1));
    tbl[4] = mk(2'b10, 2'b00, 4'b1000, 2'b10, 2'd2, 1'b0, c4(1,1,3,1));
    tbl[5] = mk(2'b00, 2'b00, 4'b1000, 2'b00, 2'd2, 1'b0, c4(1,1,3,1));
    tbl[6] = mk(2'b10, 2'b00, 4'b1000, 2'b10, 2'd2, 1'b0, c4(1,1,4,1));
    tbl[7] = mk(2'b00, 2'b00, 4'b1000, 2'b00, 2'd2, 1'b0, c4(1,1,4,1));
    tbl[8] = mk(2'b10, 2'b10, 4'b0000, 2'b10, 2'd0, 1'b1, c4(1,1,4,1));
    tbl[9] = mk(2'b00, 2'b00, 4'b0000, 2'b00, 2'd0, 1'b1, c4(1,1,4,1));

    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_buf", ack_buf, 0);
    chk("rst_new", ack_new, 0);
    chk("rst_cnt", cnt_flat, c4(1,1,1,1));

    for (int k = 0; k < 10; k++) begin
      req_vld = tbl[k].vld; req_new = tbl[k].nw; req_buf = tbl[k].bf;
      step();
      chk($sformatf("tbl%0d_ack", k), ack, tbl[k].e_ack);
      chk($sformatf("tbl%0d_buf", k), ack_buf, tbl[k].e_buf);
      chk($sformatf("tbl%0d_new", k), ack_new, tbl[k].e_new);
      chk($sformatf("tbl%0d_cnt", k), cnt_flat, tbl[k].e_cnt);
    end

    // tie between buffers 1 and 2 goes to 1
    do_reset();
    issue(0, 1'b0, 2'd0, 0, "tie_r0");
    issue(1, 1'b0, 2'd3, 3, "tie_r3");
    chk("tie_pre_cnt", cnt_flat, c4(2,1,1,2));
    issue(0, 1'b1, 2'd0, 1, "tie_new");
    chk("tie_cnt", cnt_flat, c4(2,1,1,2));

    // saturate buffer 0 then age
    do_reset();
    for (int k = 0; k < 6; k++) issue(0, 1'b0, 2'd0, 0, "age_b0");
    issue(1, 1'b0, 2'd1, 1, "age_b1");
    for (int k = 0; k < 2; k++) issue(0, 1'b0, 2'd2, 2, "age_b2");
    chk("age_pre_cnt", cnt_flat, c4(7,2,3,1));
    issue(1, 1'b0, 2'd0, 0, "age_hit");
    chk("age_cnt", cnt_flat, c4(4,1,1,0));
    issue(0, 1'b1, 2'd0, 3, "age_new");
    chk("age_post_cnt", cnt_flat, c4(4,1,1,1));

    // both held: acks alternate starting with requester 0
    do_reset();
    req_vld = 2'b11; req_new = 2'b00; req_buf = {2'd1, 2'd0};
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arb%0d_ack", k), ack, (k % 2 == 0) ? 1 : 2);
      chk($sformatf("arb%0d_buf", k), ack_buf, (k % 2 == 0) ? 0 : 1);
    end
    chk("arb_cnt", cnt_flat, c4(3,3,1,1));
    req_vld = '0;
    step();

    // reset right after acceptance drops the ack and restores the pointer
    do_reset();
    req_vld = 2'b01; req_new = 2'b00; req_buf = {2'd3, 2'd2};
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid_ack", ack, 0);
    chk("rmid_cnt", cnt_flat, c4(1,1,1,1));
    @(negedge clk);
    rst_n = 1'b1;
    req_vld = 2'b11;
    step();
    chk("rmid_re_ack", ack, 1);
    chk("rmid_re_buf", ack_buf, 2);
    chk("rmid_re_cnt", cnt_flat, c4(1,1,2,1));
    req_vld = '0;
    step();

    // randomized run against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req_vld = 2'($urandom);
      req_new[0] = ($urandom_range(0, 7) == 0);
      req_new[1] = ($urandom_range(0, 7) == 0);
      req_buf = 4'($urandom);
      model_step(req_vld, req_new, req_buf);
      step();
      chk("rnd_ack", ack, mack);
      chk("rnd_buf", ack_buf, mbuf);
      chk("rnd_new", ack_new, mnew);
      chk("rnd_cnt", cnt_flat, c4(m[0], m[1], m[2], m[3]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
